// File: rtl/lut_layer_sched.sv
// One shared 6-input LUT evaluator time-multiplexed over NUM_NEURONS neurons.
// A vector is latched in IDLE, one neuron is evaluated per EVAL cycle, and the result is held in OUT.

module lut_layer_slot #(
    parameter int SW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [63:0]     tbl_in,
    input  logic [6*SW-1:0] sel_in,
    output logic [63:0]     tbl,
    output logic [6*SW-1:0] sel
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl <= '0;
            sel <= '0;
        end else if (we) begin
            tbl <= tbl_in;
            sel <= sel_in;
        end
    end
endmodule

module lut_layer_sched #(
    parameter int NUM_NEURONS = 8,
    parameter int IN_WIDTH    = 64,
    localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int SW = $clog2(IN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [63:0]            cfg_table,
    input  logic [6*SW-1:0]        cfg_sel,
    output logic                   cfg_ready,
    input  logic                   s_valid,
    input  logic [IN_WIDTH-1:0]    s_data,
    output logic                   s_ready,
    output logic                   m_valid,
    output logic [NUM_NEURONS-1:0] m_data,
    input  logic                   m_ready,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

    state_t                              state, state_nxt;
    logic [AW-1:0]                       n;
    logic [IN_WIDTH-1:0]                 vec;
    logic [NUM_NEURONS-1:0]              result;
    logic [NUM_NEURONS-1:0]              slot_we;
    logic [NUM_NEURONS-1:0][63:0]        tbls;
    logic [NUM_NEURONS-1:0][6*SW-1:0]    sels;
    logic [63:0]                         cur_tbl;
    logic [6*SW-1:0]                     cur_sel;
    logic [5:0]                          lut_addr;
    logic                                lut_bit;

    // Slot g only matches its own index, so addresses >= NUM_NEURONS write nothing.
    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_slot
        assign slot_we[g] = cfg_we && cfg_ready && (cfg_addr == AW'(g));
        lut_layer_slot #(.SW(SW)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .we     (slot_we[g]),
            .tbl_in (cfg_table),
            .sel_in (cfg_sel),
            .tbl    (tbls[g]),
            .sel    (sels[g])
        );
    end

    always_comb begin
        cur_tbl = tbls[n];
        cur_sel = sels[n];
        lut_addr = '0;
        for (int k = 0; k < 6; k++)
            lut_addr[k] = vec[cur_sel[k*SW +: SW]];
        lut_bit = cur_tbl[lut_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid)    state_nxt = EVAL;
            EVAL:    if (n == LAST)  state_nxt = OUT;
            OUT:     if (m_ready)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Ready outputs are gated by rst so nothing is offered while reset is held.
    always_comb begin
        s_ready   = (state == IDLE) && !rst;
        cfg_ready = (state == IDLE) && !rst;
        busy      = (state != IDLE);
        m_valid   = (state == OUT);
        m_data    = result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec    <= '0;
            n      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (s_valid) begin
                    vec    <= s_data;
                    n      <= '0;
                    result <= '0;
                end
                EVAL: begin
                    result[n] <= lut_bit;
                    n         <= (n == LAST) ? '0 : n + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_layer_sched.sv
// Directed bench for lut_layer_sched: default 8x64 instance plus a 6-neuron instance for address range checks.

module tb_lut_layer_sched;
    logic        clk = 0;
    logic        rst = 1;
    logic        cfg_we = 0;
    logic [2:0]  cfg_addr = 0;
    logic [63:0] cfg_table = 0;
    logic [35:0] cfg_sel = 0;
    logic        cfg_ready;
    logic        s_valid = 0;
    logic [63:0] s_data = 0;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 0;
    logic        busy;

    logic        c2_we = 0;
    logic [2:0]  c2_addr = 0;
    logic [63:0] c2_table = 0;
    logic [17:0] c2_sel = 0;
    logic        c2_ready;
    logic        s2_valid = 0;
    logic [7:0]  s2_data = 0;
    logic        s2_ready;
    logic        m2_valid;
    logic [5:0]  m2_data;
    logic        m2_ready = 1;
    logic        busy2;

    int checks = 0;
    int failures = 0;

    localparam logic [35:0] IDENT = {6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
    localparam logic [63:0] T0    = 64'h0000_0000_00A0_00A0;

    always #5 clk = ~clk;

    lut_layer_sched dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_table(cfg_table),
        .cfg_sel(cfg_sel), .cfg_ready(cfg_ready), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy)
    );

    lut_layer_sched #(.NUM_NEURONS(6), .IN_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(c2_we), .cfg_addr(c2_addr), .cfg_table(c2_table),
        .cfg_sel(c2_sel), .cfg_ready(c2_ready), .s_valid(s2_valid), .s_data(s2_data),
        .s_ready(s2_ready), .m_valid(m2_valid), .m_data(m2_data), .m_ready(m2_ready), .busy(busy2)
    );

    task automatic cfg_write(input logic [2:0] a, input logic [63:0] t, input logic [35:0] s);
        cfg_we = 1; cfg_addr = a; cfg_table = t; cfg_sel = s;
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    // Accept d on the next edge, scramble s_data, then wait for m_valid and handshake.
    task automatic run_vec(input logic [63:0] d, output logic [7:0] res, output int lat);
        s_data = d; s_valid = 1;
        @(posedge clk); #1;
        s_valid = 0; s_data = ~d;
        lat = 1;
        while (!m_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = m_data;
        m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
    endtask

    task automatic test_reset;
        logic [7:0] res;
        int lat;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, cfg_ready, busy, m_valid, m_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b cfg=%b busy=%b mv=%b md=%h, want all 0",
                     s_ready, cfg_ready, busy, m_valid, m_data);
        end
        rst = 0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready: got s_ready=%b cfg_ready=%b, want 1 1", s_ready, cfg_ready);
        end
        run_vec(64'hFFFF_FFFF_FFFF_FFFF, res, lat);
        checks++;
        if (res !== 8'h00 || lat !== 9) begin
            failures++;
            $display("FAIL unconfigured: got m_data=%h lat=%0d, want 00 lat=9", res, lat);
        end
    endtask

    task automatic test_neuron_select;
        logic [7:0] res;
        int lat;
        cfg_write(3'd3, 64'h8000_0000_0000_0000, IDENT);
        cfg_write(3'd5, 64'h2, {6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd40});
        run_vec(64'h3F, res, lat);
        checks++;
        if (res !== 8'h08 || lat !== 9) begin
            failures++;
            $display("FAIL n3_hit: got m_data=%h lat=%0d, want 08 lat=9", res, lat);
        end
        run_vec(64'h1F, res, lat);
        checks++;
        if (res !== 8'h00) begin
            failures++;
            $display("FAIL n3_miss: got m_data=%h, want 00", res);
        end
        run_vec(64'h1 << 40, res, lat);
        checks++;
        if (res !== 8'h20) begin
            failures++;
            $display("FAIL n5_scatter_hit: got m_data=%h, want 20", res);
        end
        run_vec((64'h1 << 40) | (64'h1 << 59), res, lat);
        checks++;
        if (res !== 8'h00) begin
            failures++;
            $display("FAIL n5_scatter_miss: got m_data=%h, want 00", res);
        end
    endtask

    task automatic test_sweep;
        logic [7:0] res, exp;
        int lat;
        cfg_write(3'd0, T0, IDENT);
        for (int v = 0; v < 64; v++) begin
            run_vec(64'(v), res, lat);
            exp = 8'h00;
            exp[0] = T0[v];
            exp[3] = (v == 63);
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL sweep v=%0d: got m_data=%h, want %h", v, res, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        s_data = 64'h3F; s_valid = 1;
        @(posedge clk); #1;
        s_data = 64'h07;
        repeat (8) @(posedge clk);
        #1;
        cfg_we = 1; cfg_addr = 3'd1; cfg_table = '1; cfg_sel = IDENT;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h08 || s_ready !== 1'b0 || cfg_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_out c%0d: got mv=%b md=%h rdy=%b cfg=%b, want 1 08 0 0",
                         i, m_valid, m_data, s_ready, cfg_ready);
            end
            @(posedge clk); #1;
        end
        cfg_we = 0;
        m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_handshake: got mv=%b rdy=%b busy=%b, want 0 1 0", m_valid, s_ready, busy);
        end
        @(posedge clk); #1;
        s_valid = 0;
        lat = 1;
        while (!m_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (m_data !== 8'h01 || lat !== 9) begin
            failures++;
            $display("FAIL second_vec: got m_data=%h lat=%0d, want 01 lat=9", m_data, lat);
        end
        m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
    endtask

    task automatic test_mid_reset;
        logic [7:0] res;
        int lat;
        s_data = 64'h3F; s_valid = 1;
        @(posedge clk); #1;
        s_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_eval: got %b, want 1", busy);
        end
        rst = 1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 8'h00 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got mv=%b busy=%b md=%h rdy=%b, want 0 0 00 0",
                     m_valid, busy, m_data, s_ready);
        end
        @(posedge clk); #1;
        rst = 0;
        run_vec(64'h3F, res, lat);
        checks++;
        if (res !== 8'h00 || lat !== 9) begin
            failures++;
            $display("FAIL post_reset_cleared: got m_data=%h lat=%0d, want 00 lat=9", res, lat);
        end
        run_vec(64'h07, res, lat);
        checks++;
        if (res !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_n0_cleared: got m_data=%h, want 00", res);
        end
        cfg_write(3'd3, 64'h8000_0000_0000_0000, IDENT);
        run_vec(64'h3F, res, lat);
        checks++;
        if (res !== 8'h08) begin
            failures++;
            $display("FAIL post_reset_reconfig: got m_data=%h, want 08", res);
        end
    endtask

    task automatic test_cfg_ignore;
        logic [7:0] res;
        int lat;
        s_data = 64'h3F; s_valid = 1;
        @(posedge clk); #1;
        s_valid = 0;
        @(posedge clk); #1;
        cfg_we = 1; cfg_addr = 3'd2; cfg_table = '1; cfg_sel = IDENT;
        @(posedge clk); #1;
        cfg_we = 0;
        lat = 3;
        while (!m_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (m_data !== 8'h08 || lat !== 9) begin
            failures++;
            $display("FAIL cfg_in_eval_result: got m_data=%h lat=%0d, want 08 lat=9", m_data, lat);
        end
        m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
        run_vec(64'h07, res, lat);
        checks++;
        if (res !== 8'h00) begin
            failures++;
            $display("FAIL cfg_in_eval_ignored: got m_data=%h, want 00", res);
        end

        // 6-neuron instance: addresses 6 and 7 are out of range and must not land anywhere.
        for (int a = 5; a < 8; a++) begin
            c2_we = 1; c2_addr = 3'(a); c2_table = '1; c2_sel = '0;
            @(posedge clk); #1;
        end
        c2_we = 0;
        s2_data = 8'h00; s2_valid = 1;
        @(posedge clk); #1;
        s2_valid = 0;
        lat = 1;
        while (!m2_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (m2_data !== 6'h20 || lat !== 7) begin
            failures++;
            $display("FAIL addr_range: got m_data=%h lat=%0d, want 20 lat=7", m2_data, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_neuron_select();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        test_cfg_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
